cache_mem_bridge: RTL

//  Downstream stage of the set-associative data cache. Converts the cache's memory-side
//  req/gnt/rvalid word interface into single-port synchronous SRAM accesses (1-cycle read latency).

---
 rtl/cache_mem_bridge.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/cache_mem_bridge.sv
// Bridges the cache's req/gnt/rvalid memory port onto a 1-cycle-latency single-port SRAM,
// with a programmable number of wait states so every access takes exactly 3+W cycles.
//
// state  | meaning
// IDLE   | ready; grant a pending request and latch it
// ACCESS | drive the SRAM cycle (suppressed for out-of-window addresses)
// LATCH  | capture SRAM read data and error flag
// WAIT   | count down the wait states sampled at grant
// RESP   | one-cycle rvalid with latched data/error
module cache_mem_bridge #(
    parameter int unsigned RAM_AW   = 16,
    parameter logic [31:0] MEM_BASE = 32'h0010_0000,
    parameter int unsigned WAIT_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       req_addr_i,
    input  logic [31:0]       req_wdata_i,
    input  logic              req_we_i,
    input  logic              req_req_i,
    input  logic [3:0]        req_be_i,
    output logic              req_gnt_o,
    output logic              req_rvalid_o,
    output logic [31:0]       req_rdata_o,
    output logic              req_error_o,
    output logic              ram_en_o,
    output logic              ram_we_o,
    output logic [3:0]        ram_be_o,
    output logic [RAM_AW-1:0] ram_addr_o,
    output logic [31:0]       ram_wdata_o,
    input  logic [31:0]       ram_rdata_i,
    input  logic [WAIT_W-1:0] wait_cycles_i,
    output logic [31:0]       req_count_o
);

    typedef enum logic [2:0] {S_IDLE, S_ACCESS, S_LATCH, S_WAIT, S_RESP} state_t;

    // Upper bound kept at 33 bits so a window ending at 4 GiB cannot wrap.
    localparam logic [32:0] MEM_END = {1'b0, MEM_BASE} + (33'd4 << RAM_AW);

    state_t              state_q, state_d;
    logic [RAM_AW-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [3:0]          be_q, be_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                err_q, err_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                error_q, error_d;
    logic [31:0]         count_q, count_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            be_q    <= '0;
            wait_q  <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            error_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        wait_d       = wait_q;
        err_d        = err_q;
        rdata_d      = rdata_q;
        error_d      = error_q;
        count_d      = count_q;
        req_gnt_o    = 1'b0;
        req_rvalid_o = 1'b0;
        req_rdata_o  = '0;
        req_error_o  = 1'b0;
        ram_en_o     = 1'b0;
        ram_we_o     = 1'b0;
        ram_be_o     = '0;

        case (state_q)
            S_IDLE: begin
                req_gnt_o = req_req_i && !reset;
                if (req_req_i) begin
                    // Base is window-aligned, so (addr - base) >> 2 is just the low address bits.
                    addr_d  = req_addr_i[RAM_AW+1:2];
                    we_d    = req_we_i;
                    wdata_d = req_wdata_i;
                    be_d    = req_be_i;
                    wait_d  = wait_cycles_i;
                    err_d   = (req_addr_i < MEM_BASE) || ({1'b0, req_addr_i} >= MEM_END);
                    count_d = count_q + 32'd1;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                ram_en_o = !err_q && !reset;
                ram_we_o = we_q && !err_q && !reset;
                ram_be_o = we_q ? be_q : 4'hF;
                state_d  = S_LATCH;
            end
            S_LATCH: begin
                rdata_d = (!we_q && !err_q) ? ram_rdata_i : 32'h0;
                error_d = err_q;
                state_d = (wait_q != '0) ? S_WAIT : S_RESP;
            end
            S_WAIT: begin
                wait_d = wait_q - 1'b1;
                if (wait_q == WAIT_W'(1)) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                req_rvalid_o = !reset;
                req_rdata_o  = reset ? 32'h0 : rdata_q;
                req_error_o  = error_q && !reset;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign ram_addr_o  = addr_q;
    assign ram_wdata_o = wdata_q;
    assign req_count_o = count_q;

endmodule
